// File: rtl/frame_tx_pkg.sv
// Shared types for the transmit frame sequencer: state encoding and header index width helper.
package frame_tx_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      HEADER  = 2'd1,
      PAYLOAD = 2'd2
   } frame_tx_state_t;

   // A single-beat header still needs a 1-bit index so the mux select is never zero-width.
   function automatic int hdr_idx_w(input int beats);
      return (beats > 1) ? $clog2(beats) : 1;
   endfunction

endpackage

// File: rtl/frame_tx_fsm.sv
// TX frame sequencer: registered header beats (first beat one cycle after capture), then a 0-latency payload pass-through
// honouring m_tready backpressure; optional frame counter when FRAME_TX_STATS_EN is defined.
module frame_tx_fsm
   import frame_tx_pkg::*;
#(
   parameter int DATA_W    = 64,
   parameter int HDR_BEATS = 2
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [HDR_BEATS*DATA_W-1:0] hdr_data,
   input  logic                        hdr_valid,
   output logic                        hdr_ready,
   input  logic [DATA_W-1:0]           s_tdata,
   input  logic                        s_tvalid,
   output logic                        s_tready,
   input  logic                        s_tlast,
   output logic [DATA_W-1:0]           m_tdata,
   output logic                        m_tvalid,
   input  logic                        m_tready,
   output logic                        m_tlast,
   output logic                        frame_start,
   output logic                        frame_end,
   output logic                        in_header,
   output logic                        in_payload
`ifdef FRAME_TX_STATS_EN
   ,
   output logic [31:0]                 frame_count
`endif
);

   localparam int                IDX_W    = hdr_idx_w(HDR_BEATS);
   localparam int                HDR_W    = HDR_BEATS * DATA_W;
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(HDR_BEATS - 1);

   frame_tx_state_t   state_q;
   frame_tx_state_t   state_d;
   logic [HDR_W-1:0]  hdr_q;
   logic [IDX_W-1:0]  idx_q;
   logic              hdr_fire;
   logic              hbeat_fire;
   logic [DATA_W-1:0] hdr_beat;

   assign hdr_beat   = hdr_q[idx_q*DATA_W +: DATA_W];
   assign in_header  = (state_q == HEADER);
   assign in_payload = (state_q == PAYLOAD);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         hdr_q   <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         if (hdr_fire) begin
            hdr_q <= hdr_data;
            idx_q <= '0;
         end else if (hbeat_fire && (idx_q != LAST_IDX)) begin
            // The index parks on the last beat; the next capture clears it.
            idx_q <= idx_q + IDX_W'(1);
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      hdr_ready   = 1'b0;
      s_tready    = 1'b0;
      m_tdata     = '0;
      m_tvalid    = 1'b0;
      m_tlast     = 1'b0;
      frame_start = 1'b0;
      frame_end   = 1'b0;
      hdr_fire    = 1'b0;
      hbeat_fire  = 1'b0;
      case (state_q)
         IDLE: begin
            hdr_ready = 1'b1;
            if (hdr_valid) begin
               hdr_fire    = 1'b1;
               frame_start = 1'b1;
               state_d     = HEADER;
            end
         end
         HEADER: begin
            m_tdata  = hdr_beat;
            m_tvalid = 1'b1;
            if (m_tready) begin
               hbeat_fire = 1'b1;
               if (idx_q == LAST_IDX) begin
                  state_d = PAYLOAD;
               end
            end
         end
         PAYLOAD: begin
            m_tdata  = s_tdata;
            m_tvalid = s_tvalid;
            m_tlast  = s_tlast;
            s_tready = m_tready;
            if (s_tvalid && m_tready && s_tlast) begin
               frame_end = 1'b1;
               state_d   = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

`ifdef FRAME_TX_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_count <= '0;
      end else if (frame_end) begin
         frame_count <= frame_count + 32'd1;
      end
   end
`endif

endmodule

// File: doc/frame_tx_fsm.md
# frame_tx_fsm

Transmit-side frame sequencer for the Ethernet datapath. It accepts a pre-built header as one parallel word, emits it as `HDR_BEATS` beats on an AXI-Stream master, then forwards the payload stream until `s_tlast`. It sits between the header builder and the MAC TX interface, and exposes the same lifecycle flags as the receive-side parser: `frame_start`, `frame_end`, `in_header` and `in_payload`.

## Interface
- `DATA_W`, 64: stream data width in bits.
- `HDR_BEATS`, 2: header length in beats. Must be ≥1.
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `hdr_data`  in  `HDR_BEATS*DATA_W`  header image; beat k is `hdr_data[k*DATA_W +: DATA_W]`.
- `hdr_valid`  in  1  header offered.
- `hdr_ready`  out  1  header accepted this cycle when high together with `hdr_valid`.
- `s_tdata`  in  `DATA_W`  payload data.
- `s_tvalid`  in  1  payload beat valid.
- `s_tready`  out  1  payload ready.
- `s_tlast`  in  1  last payload beat.
- `m_tdata`  out  `DATA_W`  output data.
- `m_tvalid`  out  1  output valid.
- `m_tready`  in  1  downstream ready.
- `m_tlast`  out  1  last output beat.
- `frame_start`  out  1  one-cycle pulse on header capture.
- `frame_end`  out  1  one-cycle pulse on acceptance of the last output beat.
- `in_header`  out  1  high while state is HEADER.
- `in_payload`  out  1  high while state is PAYLOAD.

## Operation
- States are IDLE, HEADER and PAYLOAD. Reset state is IDLE.
- **IDLE**
  - `hdr_ready`=1, `s_tready`=0, `m_tvalid`=0.
  - On `hdr_valid`: register `hdr_data`, clear the beat index, pulse `frame_start`, go to HEADER.
- **HEADER**
  - `m_tdata` = header beat[idx], `m_tvalid`=1, `m_tlast`=0, `s_tready`=0, `hdr_ready`=0.
  - On `m_tready`: idx increments.
  - When the beat at idx=`HDR_BEATS`-1 is accepted, go to PAYLOAD.
- **PAYLOAD**
  - Combinational pass-through: `m_tdata`=`s_tdata`, `m_tvalid`=`s_tvalid`, `m_tlast`=`s_tlast`, `s_tready`=`m_tready`.
  - When `s_tvalid && m_tready && s_tlast`, pulse `frame_end` and go to IDLE.
- Beat index width is `$clog2(HDR_BEATS)`, minimum 1. It never wraps: the transition out of HEADER occurs at `HDR_BEATS`-1.
- Every payload must carry ≥1 beat. A header-only frame is not supported.
- `m_tdata` is 0 in IDLE.
- The registered header is held stable for the whole HEADER state.
- `hdr_data` changes after capture have no effect.
- A `s_tvalid` arriving early (in IDLE or HEADER) is back-pressured and never dropped.
- If `m_tready` is held low in HEADER, the same beat stays presented and `m_tvalid` stays high (AXI-Stream stability rule).

## Timing
- Reset values: `hdr_ready`=1 (state is IDLE); all other outputs 0; header register 0; idx 0.
- Asserting `rst_n` low mid-frame returns to IDLE immediately. The partial frame is abandoned with no `frame_end` and no `m_tlast`.
- Header accepted at cycle N → header beat 0 valid at N+1.
- Back-to-back with `m_tready`=1, a frame of P payload beats occupies `HDR_BEATS`+P+1 cycles.
- Last payload beat accepted at cycle M → `hdr_ready`=1 at M+1. There is a mandatory one-cycle IDLE gap between frames.
- Payload path latency is 0 cycles (combinational).
- Header beats and state are registered.

## Configuration
- `FRAME_TX_STATS_EN`
  - Defined: adds output `frame_count` (32-bit), which increments on each `frame_end`, wraps from 0xFFFF_FFFF to 0, and resets to 0.
  - Undefined: the port and the counter are absent, and behaviour is otherwise identical.

## Structure
- Package `frame_tx_pkg` holds `frame_tx_state_t` (IDLE/HEADER/PAYLOAD).
  - The package also holds the localparam function for index width, `hdr_idx_w(HDR_BEATS)`.
- Single module, with no sub-module. The header beat mux is inline.

## Test plan
- **Basic frame.** `HDR_BEATS`=2, header 0x11..11/0x22..22, 3 payload beats with `m_tready`=1.
  - Output: 0x11.., 0x22.., then P0, P1, P2.
  - `m_tlast` only on P2.
  - `frame_start` at capture, `frame_end` on P2, `hdr_ready` high the next cycle.
- **Header backpressure.** `m_tready`=0 for 4 cycles on header beat 1.
  - `m_tdata` holds 0x22.. and `m_tvalid` stays 1.
  - `s_tready` stays 0 throughout.
- **Early payload.** `s_tvalid`=1 from the cycle after capture.
  - No payload beat is consumed before both header beats are accepted.
  - P0 appears immediately after header beat 1.
- **Single-beat payload plus back-to-back frames.**
  - Two frames with P=1 and `hdr_valid` held high: each takes 4 cycles.
  - There is exactly one IDLE cycle between frames.
- **Reset mid-payload.** Pull `rst_n` low after P0.
  - All outputs go to reset values asynchronously, with no `frame_end`.
  - The next frame transmits correctly.
- **With `FRAME_TX_STATS_EN`.** Send 3 frames → `frame_count`=3. Preload 0xFFFF_FFFF via force, send one frame → `frame_count`=0.
